// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants, depth helper and status struct for the sync FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - dual-port storage: one write port, one registered read port
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array itself is never cleared; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock FIFO with thresholds and sticky errors
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] FIFO_data_in,
  input  logic                  write_enable,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] FIFO_data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error_overflow,
  output logic                  error_underflow
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  fifo_status_t          status;

  // Occupancy alone separates full from empty, since pointers coincide in both.
  assign status.full         = (count == DEPTH_C);
  assign status.empty        = (count == '0);
  assign status.almost_full  = (count >= AF_C);
  assign status.almost_empty = (count <= AE_C);

  assign full         = status.full;
  assign empty        = status.empty;
  assign almost_full  = status.almost_full;
  assign almost_empty = status.almost_empty;

  assign rd_acc = read_enable & ~status.empty;
  assign wr_acc = write_enable & (~status.full | rd_acc);

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc & ~reset),
    .wr_addr (wr_ptr),
    .wr_data (FIFO_data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (FIFO_data_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      valid_out       <= 1'b0;
      error_overflow  <= 1'b0;
      error_underflow <= 1'b0;
    end else begin
      valid_out       <= rd_acc;
      error_overflow  <= error_overflow | (write_enable & ~wr_acc);
      error_underflow <= error_underflow | (read_enable & ~rd_acc);
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + (ADDR_WIDTH+1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - (ADDR_WIDTH+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - directed table-driven bench for fifo_sync_param
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] FIFO_data_in;
  logic       write_enable;
  logic       read_enable;
  logic [7:0] FIFO_data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       error_overflow;
  logic       error_underflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .AF_THRESH  (3),
    .AE_THRESH  (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .FIFO_data_in    (FIFO_data_in),
    .write_enable    (write_enable),
    .read_enable     (read_enable),
    .FIFO_data_out   (FIFO_data_out),
    .valid_out       (valid_out),
    .full            (full),
    .empty           (empty),
    .almost_full     (almost_full),
    .almost_empty    (almost_empty),
    .count           (count),
    .error_overflow  (error_overflow),
    .error_underflow (error_underflow)
  );

  typedef struct {
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [7:0] dout;
    logic       v;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, we, re, input logic [7:0] din, dout,
                              input logic v, input int cnt, input logic ovf, unf);
    vec_t t;
    t.rst = rst; t.we = we; t.re = re; t.din = din; t.dout = dout;
    t.v = v; t.cnt = cnt; t.ovf = ovf; t.unf = unf;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic rst, we, re, input logic [7:0] din);
    reset = rst; write_enable = we; read_enable = re; FIFO_data_in = din;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_state(input int idx, input logic [7:0] dout, input logic v,
                             input int cnt, input logic ovf, unf);
    chk("data_out",  idx, 32'(FIFO_data_out), 32'(dout));
    chk("valid_out", idx, 32'(valid_out), 32'(v));
    chk("count",     idx, 32'(count), 32'(cnt));
    chk("full",      idx, 32'(full), 32'(cnt == 4));
    chk("empty",     idx, 32'(empty), 32'(cnt == 0));
    chk("almost_full",  idx, 32'(almost_full), 32'(cnt >= 3));
    chk("almost_empty", idx, 32'(almost_empty), 32'(cnt <= 1));
    chk("overflow",  idx, 32'(error_overflow), 32'(ovf));
    chk("underflow", idx, 32'(error_underflow), 32'(unf));
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; read_enable = 1'b0; FIFO_data_in = 8'h00;

    //                rst we re din    dout   v cnt ovf unf
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hFF, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hAF, 8'h00, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h17, 8'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'hB8, 8'h00, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h6A, 8'h00, 0, 4, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hFF, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hAF, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h17, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hB8, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'hB8, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 8'h11, 8'hB8, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h11, 8'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h22, 8'h00, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h33, 8'h00, 0, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h44, 8'h00, 0, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h5C, 8'h11, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h60, 8'h22, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h61, 8'h33, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h62, 8'h44, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h63, 8'h5C, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h64, 8'h60, 1, 4, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h65, 8'h61, 1, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h62, 1, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h63, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h64, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h65, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 8'h65, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].din);
      check_state(i, vecs[i].dout, vecs[i].v, vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
    end

    // Reset mid-operation with both enables high: reset wins and contents are discarded.
    step(0, 1, 0, 8'hA1);
    step(0, 1, 0, 8'hA2);
    step(0, 1, 1, 8'hA3);
    check_state(100, 8'hA1, 1, 2, 0, 0);
    step(0, 1, 0, 8'hA4);
    check_state(101, 8'hA1, 0, 3, 0, 0);
    step(1, 1, 1, 8'hFF);
    check_state(102, 8'h00, 0, 0, 0, 0);
    step(0, 0, 1, 8'h00);
    check_state(103, 8'h00, 0, 0, 0, 1);
    step(0, 0, 0, 8'h00);
    check_state(104, 8'h00, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO that owns its own write/read pointers, occupancy count and status flags.
- Wraps a dual-port storage array, so producers and consumers only drive enables and data.
- Successor to the bare pointer-addressed memory: adds full/empty, programmable almost-full/almost-empty thresholds, sticky overflow/underflow errors and a registered read-valid.
- Sits between a producer and a consumer stage in the datapath, both on one clock.

Parameters:
- DATA_WIDTH, 8, width of each FIFO word.
- ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_THRESH, 3, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- FIFO_data_in  input  DATA_WIDTH  write data.
- write_enable  input  1  write request.
- read_enable  input  1  read request.
- FIFO_data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  FIFO_data_out holds a word popped on the previous edge.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- error_overflow  output  1  sticky; a write was dropped.
- error_underflow  output  1  sticky; a read was rejected.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset values, applied at the first rising edge with reset=1:
  - wr_ptr=0, rd_ptr=0, count=0.
  - FIFO_data_out=0, valid_out=0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - error_overflow=0, error_underflow=0.
  - Storage contents are not reset.
- Reset has priority over all other inputs. Reset asserted mid-operation discards all contents at that edge.
- rd_acc = read_enable & !empty.
- wr_acc = write_enable & (!full | rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= FIFO_data_in; wr_ptr increments modulo DEPTH.
- On rd_acc: FIFO_data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Read latency is one edge. valid_out <= rd_acc. FIFO_data_out holds its value when there is no rd_acc.
- Count update per edge:
  - +1 for wr_acc only.
  - -1 for rd_acc only.
  - Unchanged for both or neither.
- When empty, a simultaneous read and write gives wr_acc only; the read is rejected (no read-through).
- Flags are combinational from the registered count, so they update in the cycle after the edge that changes count.
- error_overflow sets on write_enable & !wr_acc.
- error_underflow sets on read_enable & !rd_acc.
- Both error flags clear only on reset.
- Pointer wrap: full and empty are distinguished via count, never by pointer compare.

Decomposition:
- Package fifo_pkg holds:
  - Default width and depth constants.
  - A function computing DEPTH from ADDR_WIDTH.
  - A status struct typedef (full, empty, almost_full, almost_empty).
- One sub-module: fifo_mem_dp, a dual-port array with one write port and one synchronous read port, same DATA_WIDTH/ADDR_WIDTH parameters. The top holds pointers, count, flags and errors.

Test Plan (defaults: DATA_WIDTH=8, ADDR_WIDTH=2, AF=3, AE=1):
1. Reset, then write FF, AF, 17, B8 on 4 edges -> empty=0 after edge 1; almost_empty=0 after edge 2; almost_full=1 after edge 3; full=1, count=4 after edge 4.
2. Full, write 6A without read -> word dropped, count=4, error_overflow=1 and stays 1.
3. Read 4 times -> FIFO_data_out = FF, AF, 17, B8, each with valid_out=1 one edge after its read; empty=1 after the last read.
4. Empty, read_enable=1 -> error_underflow=1, valid_out=0, FIFO_data_out holds B8. Empty with read and write together -> write accepted, count=1.
5. Fill to count=4, then simultaneous read+write of 5C -> both accepted, count=4, full=1, no overflow. Continue 6 push/pop cycles -> pointers wrap and data order is preserved.
6. Write 3 words, assert reset one cycle -> all reset values at that edge. Following read -> error_underflow=1, valid_out=0.
